l2_snoop_responder: RTL and testbench

Memory-side responder for the two L1 snooper interfaces (L1a, L1b). It services line-fill read requests and dirty-line eviction writes. It holds a behavioural 128-bit-line backing store and returns fills with fixed latency on each L1's update bus. Fills are held until the L1 is free of hotlink interrupts, so a fill is never lost while an L1 is servicing its neighbour.

---
 rtl/l2_snoop_responder.sv | 165 ++++++++++++++++
 tb/tb_l2_snoop_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_snoop_responder.sv
// Memory-side responder for two L1 snoopers: eviction writes into a 128-bit-line
// backing store, and fixed-latency line fills held stable until the L1 drops hold.
module l2_snoop_responder #(
    parameter int LATENCY = 4,
    parameter int LINE_AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  a_addr,
    input  logic         a_read_valid,
    input  logic         a_eviction_wren,
    input  logic [127:0] a_evict_line,
    input  logic         a_hold,
    output logic [127:0] a_update_line,
    output logic         a_update_valid,
    output logic         a_busy,
    input  logic [31:0]  b_addr,
    input  logic         b_read_valid,
    input  logic         b_eviction_wren,
    input  logic [127:0] b_evict_line,
    input  logic         b_hold,
    output logic [127:0] b_update_line,
    output logic         b_update_valid,
    output logic         b_busy,
    output logic [1:0]   proto_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    // Handshake: x_read_valid is accepted only in IDLE; the fill is offered with
    // x_update_valid held high and data stable, and completes in the first cycle
    // it is high while x_hold is low.

    logic [127:0] store [2**LINE_AW];

    logic [1:0]                read_valid;
    logic [1:0]                wren;
    logic [1:0]                hold;
    logic [1:0][LINE_AW-1:0]   wr_idx;
    logic [1:0][127:0]         evict_line;
    logic                      unused_addr_bits;

    assign read_valid = {b_read_valid, a_read_valid};
    assign wren       = {b_eviction_wren, a_eviction_wren};
    assign hold       = {b_hold, a_hold};
    assign wr_idx     = {b_addr[LINE_AW+3:4], a_addr[LINE_AW+3:4]};
    assign evict_line = {b_evict_line, a_evict_line};
    assign unused_addr_bits = ^{a_addr[31:LINE_AW+4], a_addr[3:0],
                                b_addr[31:LINE_AW+4], b_addr[3:0]};

    state_t               state_q [2];
    state_t               state_d [2];
    logic [3:0]           cnt_q   [2];
    logic [3:0]           cnt_d   [2];
    logic [LINE_AW-1:0]   idx_q   [2];
    logic [LINE_AW-1:0]   idx_d   [2];
    logic [127:0]         resp_q  [2];
    logic [127:0]         resp_d  [2];
    logic [127:0]         rd_data [2];
    logic [1:0]           valid_q;
    logic [1:0]           valid_d;
    logic [1:0]           err_q;
    logic [1:0]           err_d;
    logic [1:0]           gnt_req;
    logic [1:0]           gnt;
    logic                 collide;

    always_comb begin
        collide = wren[0] && wren[1] && (wr_idx[0] == wr_idx[1]);
        gnt_req = '0;
        for (int p = 0; p < 2; p++) begin
            gnt_req[p] = (state_q[p] == WAIT) && (cnt_q[p] == 4'd0);
        end
        // Single store read port: A always wins a same-cycle grant.
        gnt = {gnt_req[1] && !gnt_req[0], gnt_req[0]};

        err_d = '0;
        for (int p = 0; p < 2; p++) begin
            // Bypass same-cycle evictions into the fill; A's data applied last wins.
            rd_data[p] = store[idx_q[p]];
            if (wren[1] && (wr_idx[1] == idx_q[p])) rd_data[p] = evict_line[1];
            if (wren[0] && (wr_idx[0] == idx_q[p])) rd_data[p] = evict_line[0];

            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            idx_d[p]   = idx_q[p];
            resp_d[p]  = resp_q[p];
            valid_d[p] = valid_q[p];

            case (state_q[p])
                IDLE: begin
                    if (read_valid[p]) begin
                        idx_d[p]   = wr_idx[p];
                        cnt_d[p]   = CNT_LOAD;
                        state_d[p] = WAIT;
                    end
                end
                WAIT: begin
                    err_d[p] = read_valid[p];
                    if (cnt_q[p] != 4'd0) begin
                        cnt_d[p] = cnt_q[p] - 4'd1;
                    end else if (gnt[p]) begin
                        resp_d[p]  = rd_data[p];
                        state_d[p] = RESP;
                        valid_d[p] = 1'b1;
                    end
                end
                RESP: begin
                    err_d[p] = read_valid[p];
                    if (!hold[p]) begin
                        state_d[p] = IDLE;
                        valid_d[p] = 1'b0;
                    end
                end
                default: begin
                    state_d[p] = IDLE;
                    valid_d[p] = 1'b0;
                end
            endcase
        end
        err_d[1] = err_d[1] | collide;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                cnt_q[p]   <= '0;
                idx_q[p]   <= '0;
                resp_q[p]  <= '0;
            end
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
                idx_q[p]   <= idx_d[p];
                resp_q[p]  <= resp_d[p];
            end
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Behavioural backing store, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wren[0]) store[wr_idx[0]] <= evict_line[0];
        if (wren[1] && !collide) store[wr_idx[1]] <= evict_line[1];
    end

    assign a_update_line  = resp_q[0];
    assign a_update_valid = valid_q[0];
    assign a_busy         = (state_q[0] != IDLE);
    assign b_update_line  = resp_q[1];
    assign b_update_valid = valid_q[1];
    assign b_busy         = (state_q[1] != IDLE);
    assign proto_err      = err_q;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Bench for l2_snoop_responder: directed scenarios plus random traffic, all checked
// every cycle against a transaction-timed reference model.
module tb_l2_snoop_responder;
    localparam int LAT = 4;
    localparam int AW  = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a_addr = '0, b_addr = '0;
    logic         a_read_valid = 1'b0, b_read_valid = 1'b0;
    logic         a_eviction_wren = 1'b0, b_eviction_wren = 1'b0;
    logic [127:0] a_evict_line = '0, b_evict_line = '0;
    logic         a_hold = 1'b0, b_hold = 1'b0;
    logic [127:0] a_update_line, b_update_line;
    logic         a_update_valid, b_update_valid;
    logic         a_busy, b_busy;
    logic [1:0]   proto_err;

    l2_snoop_responder #(.LATENCY(LAT), .LINE_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_read_valid(a_read_valid), .a_eviction_wren(a_eviction_wren),
        .a_evict_line(a_evict_line), .a_hold(a_hold), .a_update_line(a_update_line),
        .a_update_valid(a_update_valid), .a_busy(a_busy),
        .b_addr(b_addr), .b_read_valid(b_read_valid), .b_eviction_wren(b_eviction_wren),
        .b_evict_line(b_evict_line), .b_hold(b_hold), .b_update_line(b_update_line),
        .b_update_valid(b_update_valid), .b_busy(b_busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each read is granted at request edge + LAT-1 (A first on ties),
    // then offered until an edge that samples hold low.
    logic [127:0]  mstore [1<<AW];
    bit            m_wait [2];
    bit            m_dlv  [2];
    int            m_gedge[2];
    logic [AW-1:0] m_idx  [2];
    logic [127:0]  m_line [2];
    logic [1:0]    m_err;
    int            edge_n = 0;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_wait[p] = 0; m_dlv[p] = 0; m_line[p] = '0; m_idx[p] = '0; m_gedge[p] = 0;
        end
        m_err = '0;
    endtask

    task automatic model_edge();
        bit rv[2], wr[2], hd[2], elig[2], gnt[2];
        logic [AW-1:0] wi[2];
        logic [127:0] wl[2];
        logic [127:0] d;
        bit coll, busy_pre;
        rv[0] = a_read_valid;    rv[1] = b_read_valid;
        wr[0] = a_eviction_wren; wr[1] = b_eviction_wren;
        hd[0] = a_hold;          hd[1] = b_hold;
        wi[0] = a_addr[AW+3:4];  wi[1] = b_addr[AW+3:4];
        wl[0] = a_evict_line;    wl[1] = b_evict_line;
        coll = wr[0] && wr[1] && (wi[0] == wi[1]);
        for (int p = 0; p < 2; p++) elig[p] = m_wait[p] && (edge_n >= m_gedge[p]);
        gnt[0] = elig[0];
        gnt[1] = elig[1] && !elig[0];
        m_err = '0;
        for (int p = 0; p < 2; p++) begin
            busy_pre = m_wait[p] || m_dlv[p];
            if (rv[p] && busy_pre) m_err[p] = 1'b1;
            if (m_dlv[p] && !hd[p]) m_dlv[p] = 0;
            if (gnt[p]) begin
                d = mstore[m_idx[p]];
                if (wr[1] && wi[1] == m_idx[p]) d = wl[1];
                if (wr[0] && wi[0] == m_idx[p]) d = wl[0];
                m_line[p] = d; m_wait[p] = 0; m_dlv[p] = 1;
            end
            if (rv[p] && !busy_pre) begin
                m_wait[p] = 1; m_idx[p] = wi[p]; m_gedge[p] = edge_n + LAT - 1;
            end
        end
        if (coll) m_err[1] = 1'b1;
        if (wr[0]) mstore[wi[0]] = wl[0];
        if (wr[1] && !coll) mstore[wi[1]] = wl[1];
        edge_n++;
    endtask

    task automatic check_outputs();
        check("a_valid", a_update_valid, m_dlv[0]);
        check("a_busy", a_busy, m_wait[0] | m_dlv[0]);
        check("a_line", a_update_line, m_line[0]);
        check("b_valid", b_update_valid, m_dlv[1]);
        check("b_busy", b_busy, m_wait[1] | m_dlv[1]);
        check("b_line", b_update_line, m_line[1]);
        check("proto_err", proto_err, m_err);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clr();
        a_read_valid = 0; a_eviction_wren = 0; a_hold = 0;
        b_read_valid = 0; b_eviction_wren = 0; b_hold = 0;
    endtask

    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[AW+3:4] = AW'(idx);
        return a;
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] K_DEAD = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] K_55   = {32{4'h5}};
    localparam logic [127:0] K_2B   = 128'h0000_002B_CAFE_F00D_1234_5678_9ABC_DEF0;

    initial begin
        logic [127:0] x_line;
        logic [127:0] a_data;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_a_valid", a_update_valid, 1'b0);
        check("rst_a_line", a_update_line, 128'h0);
        check("rst_b_busy", b_busy, 1'b0);
        check("rst_err", proto_err, 2'b00);
        reset = 0;

        for (int i = 0; i < 32; i++) begin
            a_eviction_wren = 1; a_addr = mk_addr(2 * i);     a_evict_line = rnd_line();
            b_eviction_wren = 1; b_addr = mk_addr(2 * i + 1); b_evict_line = rnd_line();
            tick();
        end
        clr();

        // Basic fill
        a_eviction_wren = 1; a_addr = 32'h0000_0090; a_evict_line = K_DEAD; tick();
        clr(); a_read_valid = 1; a_addr = 32'h0000_0090; tick();
        check("fill_busy_c1", a_busy, 1'b1);
        clr(); repeat (3) tick();
        check("fill_valid_c4", a_update_valid, 1'b1);
        check("fill_data_c4", a_update_line, K_DEAD);
        tick();
        check("fill_done", a_update_valid, 1'b0);

        // Hold stretches delivery
        a_read_valid = 1; a_addr = 32'h0000_0090; tick();
        clr(); repeat (2) tick();
        a_hold = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", a_update_valid, 1'b1);
            check("hold_data", a_update_line, K_DEAD);
        end
        a_hold = 0; tick();
        check("hold_released", a_update_valid, 1'b0);
        check("hold_busy_clr", a_busy, 1'b0);

        // Grant collision
        b_eviction_wren = 1; b_addr = 32'h0000_02B0; b_evict_line = K_2B; tick();
        clr(); a_read_valid = 1; a_addr = 32'h0000_0090; b_read_valid = 1; b_addr = 32'h0000_02B0; tick();
        clr(); repeat (3) tick();
        check("coll_a_valid", a_update_valid, 1'b1);
        check("coll_b_late", b_update_valid, 1'b0);
        tick();
        check("coll_b_valid", b_update_valid, 1'b1);
        check("coll_b_data", b_update_line, K_2B);
        tick();

        // Write-to-read bypass in grant cycle
        a_read_valid = 1; a_addr = 32'h0000_0020; tick();
        clr(); repeat (2) tick();
        b_eviction_wren = 1; b_addr = 32'h0000_0020; b_evict_line = K_55; tick();
        clr();
        check("bypass_a", a_update_line, K_55);
        b_read_valid = 1; b_addr = 32'h0000_0020; tick();
        clr(); repeat (3) tick();
        check("bypass_b_valid", b_update_valid, 1'b1);
        check("bypass_b", b_update_line, K_55);
        tick();

        // Miss with aliased eviction
        x_line = rnd_line();
        a_read_valid = 1; a_addr = 32'h1000_0090; tick();
        clr(); a_eviction_wren = 1; a_addr = 32'h0000_0090; a_evict_line = x_line; tick();
        clr(); check("alias_no_err", proto_err, 2'b00);
        repeat (2) tick();
        check("alias_data", a_update_line, x_line);
        tick();

        // Request while busy
        a_read_valid = 1; a_addr = mk_addr(7); tick();
        a_data = mstore[7];
        clr(); tick();
        a_read_valid = 1; a_addr = mk_addr(3); tick();
        check("busy_req_err", proto_err, 2'b01);
        clr(); tick();
        check("busy_err_pulse", proto_err, 2'b00);
        tick();
        check("busy_orig_data", a_update_line, a_data);
        tick();

        // Same-index A+B eviction
        x_line = rnd_line();
        a_eviction_wren = 1; a_addr = mk_addr(5); a_evict_line = x_line;
        b_eviction_wren = 1; b_addr = mk_addr(5); b_evict_line = rnd_line(); tick();
        check("wcoll_err", proto_err, 2'b10);
        clr(); a_read_valid = 1; a_addr = mk_addr(5); tick();
        clr(); repeat (3) tick();
        check("wcoll_data", a_update_line, x_line);
        tick();

        // Reset during RESP
        a_read_valid = 1; a_addr = mk_addr(9); tick();
        clr(); a_hold = 1; repeat (4) tick();
        check("rst_pre_valid", a_update_valid, 1'b1);
        reset = 1;
        #1;
        check("rst_async_valid", a_update_valid, 1'b0);
        check("rst_async_busy", a_busy, 1'b0);
        model_reset();
        #1 reset = 0;
        clr(); tick();
        check("rst_idle", a_busy, 1'b0);

        // Random traffic
        repeat (3000) begin
            a_read_valid = ($urandom_range(0, 3) == 0);
            b_read_valid = ($urandom_range(0, 3) == 0);
            a_hold = ($urandom_range(0, 9) < 4);
            b_hold = ($urandom_range(0, 9) < 4);
            a_eviction_wren = ($urandom_range(0, 4) == 0);
            b_eviction_wren = ($urandom_range(0, 4) == 0);
            a_addr = mk_addr($urandom_range(0, 63));
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : mk_addr($urandom_range(0, 63));
            a_evict_line = rnd_line();
            b_evict_line = rnd_line();
            tick();
        end
        clr();
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
